// File: rtl/appmul_seq_ctrl.sv
// appmul_seq_ctrl: sequential 8x8 approximate multiplier on one shared 4:2 compressor bank; APPMUL_ERR_EN adds err.
module appmul_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
`ifdef APPMUL_ERR_EN
  ,
  output logic [15:0] err
`endif
);
  typedef enum logic [2:0] {IDLE, CMP_LO, CMP_HI, CMP_MRG, ADD, DONE} state_t;
  state_t state, state_n;
  logic [15:0] rows [8];
  logic [15:0] s0, c0, s1, c1, s2, c2;
  logic [15:0] x1, x2, x3, x4, bank_s, bank_c, approx;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE    ? (in_valid ? CMP_LO : IDLE) :
              state == CMP_LO  ? CMP_HI :
              state == CMP_HI  ? CMP_MRG :
              state == CMP_MRG ? ADD :
              state == ADD     ? DONE :
              state == DONE    ? (out_ready ? IDLE : DONE) : IDLE;
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // the one compressor bank; its four input rows are steered by state
  always_comb begin
    x1 = state == CMP_HI ? rows[4] : state == CMP_MRG ? s0 : rows[0];
    x2 = state == CMP_HI ? rows[5] : state == CMP_MRG ? c0 << 1 : rows[1];
    x3 = state == CMP_HI ? rows[6] : state == CMP_MRG ? s1 : rows[2];
    x4 = state == CMP_HI ? rows[7] : state == CMP_MRG ? c1 << 1 : rows[3];
  end
  assign bank_c = (x1 & x2) | (x1 & x3) | (x1 & x4) | (x2 & x3) | (x2 & x4);
  assign bank_s = (x1 ^ x2) ^ (x3 | x4);
  assign approx = s2 + (c2 << 1);
`ifdef APPMUL_ERR_EN
  logic [7:0]  a_r, b_r;
  logic [15:0] exact;
  assign exact = {8'b0, a_r} * {8'b0, b_r};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) rows[i] <= '0;
      {s0, c0, s1, c1, s2, c2} <= '0;
      p <= '0;
`ifdef APPMUL_ERR_EN
      a_r <= '0;
      b_r <= '0;
      err <= '0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        for (int i = 0; i < 8; i++) rows[i] <= ({8'b0, a} & {16{b[i]}}) << i;
`ifdef APPMUL_ERR_EN
        a_r <= a;
        b_r <= b;
`endif
      end
      if (state == CMP_LO) {s0, c0} <= {bank_s, bank_c};
      if (state == CMP_HI) {s1, c1} <= {bank_s, bank_c};
      if (state == CMP_MRG) {s2, c2} <= {bank_s, bank_c};
      if (state == ADD) begin
        p <= approx;
`ifdef APPMUL_ERR_EN
        err <= exact >= approx ? exact - approx : approx - exact;
`endif
      end
    end
endmodule

// File: tb/tb_appmul_seq_ctrl.sv
// tb_appmul_seq_ctrl: directed checks of latency, products, stalls and mid-operation reset.
module tb_appmul_seq_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [15:0] p;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, prev_acc = 0;
`ifdef APPMUL_ERR_EN
  logic [15:0] err;
`endif
  appmul_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
`ifdef APPMUL_ERR_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp_p,
                       input logic [15:0] exp_err, input int stall);
    a = va;
    b = vb;
    in_valid = 1;
    check("accept_ready", in_ready, 1);
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    tick();
    in_valid = 0;
    a = 8'hAA;
    b = 8'h55;
    for (int k = 0; k < 4; k++) begin
      check("busy_in_ready", in_ready, 0);
      check("busy_out_valid", out_valid, 0);
      tick();
    end
    check("done_valid", out_valid, 1);
    check("done_p", p, exp_p);
`ifdef APPMUL_ERR_EN
    check("done_err", err, exp_err);
`else
    if (exp_err != 16'hFFFF) check("done_in_ready", in_ready, 0);
`endif
    for (int k = 0; k < stall; k++) begin
      in_valid = k[0];
      a = 8'd200;
      b = 8'd200;
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_p", p, exp_p);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    check("back_idle", in_ready, 1);
    check("back_valid", out_valid, 0);
    check("hold_p", p, exp_p);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_p", p, 0);
      tick();
    end
    do_op(8'd3, 8'd3, 16'd9, 16'd0, 0);
    do_op(8'd3, 8'd12, 16'd28, 16'd8, 0);
    do_op(8'd0, 8'd255, 16'd0, 16'd0, 0);
    do_op(8'd1, 8'd1, 16'd1, 16'd0, 0);
    check("issue_spacing", 16'(acc_cyc - prev_acc), 16'd6);
    do_op(8'd3, 8'd3, 16'd9, 16'd0, 10);
    a = 8'd3;
    b = 8'd3;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("midrst_idle", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_p", p, 0);
    for (int k = 0; k < 6; k++) begin
      check("midrst_quiet", out_valid, 0);
      tick();
    end
    do_op(8'd1, 8'd1, 16'd1, 16'd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
